// File: rtl/mul_div_if.sv
// Handshake and HI/LO bus between the execute stage and the multiply/divide unit.
// The master drives operands and MTHI/MTLO writes; the slave returns status and HI/LO.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Works on operand magnitudes for one bit per cycle, then fixes signs in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_div_if.slave   bus
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   a_orig_q;
  logic               qsign_q;
  logic               rsign_q;
  logic               bzero_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;
  logic               busy_o;

  logic               sgn_op;
  logic               start_acc;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  assign sgn_op    = bus.op[0];
  assign start_acc = (state_q == IDLE) && bus.start;

  // One iteration step. Upper word is the running partial product / remainder,
  // lower word holds the multiplier / dividend bits still to be consumed.
  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, b_q});
    diff   = rem_sh[WIDTH-1:0] - b_q;
    acc_d  = acc_q;
    if (op_q[1]) begin
      if (ge) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
      else    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {msum, acc_q[WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_2w(acc_q, qsign_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == CW'(ITER - 1)) state_d = SIGN;
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      b_q      <= '0;
      a_orig_q <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            op_q     <= bus.op;
            b_q      <= neg_w(bus.srcB, sgn_op & bus.srcB[WIDTH-1]);
            acc_q    <= {{WIDTH{1'b0}}, neg_w(bus.srcA, sgn_op & bus.srcA[WIDTH-1])};
            a_orig_q <= bus.srcA;
            qsign_q  <= sgn_op & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
            rsign_q  <= sgn_op & bus.srcA[WIDTH-1];
            bzero_q  <= (bus.srcB == '0);
            cnt_q    <= '0;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
        end
        SIGN: begin
          done_q <= 1'b1;
          if (op_q[1]) begin
            // Divide by zero reports the untouched dividend rather than its magnitude.
            if (bzero_q) begin
              hi_q <= a_orig_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              lo_q <= neg_w(acc_q[WIDTH-1:0], qsign_q);
              hi_q <= neg_w(acc_q[2*WIDTH-1:WIDTH], rsign_q);
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_o;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, each operation, sign and divide-by-zero
// corners, ignored start/MTHI while busy, MTHI/MTLO writes and mid-operation reset.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally poke start/MTHI at a given busy cycle,
  // or raise both write enables together with the accepted start.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input int disturb, input logic we_at_start);
    bus.op     = op;
    bus.srcA   = a;
    bus.srcB   = b;
    bus.start  = 1'b1;
    bus.hi_we  = we_at_start;
    bus.lo_we  = we_at_start;
    bus.wdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.srcA   = '0;
    bus.srcB   = '0;
    chk1({tag, " busy@1"}, bus.busy, 1'b1);
    chk1({tag, " done@1"}, bus.done, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      if (i == disturb) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.srcA  = 32'd5;
        bus.srcB  = 32'd1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h12345678;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
    end
    chk1({tag, " busy@32"}, bus.busy, 1'b1);
    chk1({tag, " done@32"}, bus.done, 1'b0);
    @(posedge clk); #1;
    chk1({tag, " done@33"}, bus.done, 1'b1);
    chk1({tag, " busy@33"}, bus.busy, 1'b0);
    chk1({tag, " dz@33"}, bus.div_zero, edz);
    chk({tag, " hi"}, bus.hi, ehi);
    chk({tag, " lo"}, bus.lo, elo);
    @(posedge clk); #1;
    chk1({tag, " done@34"}, bus.done, 1'b0);
    chk1({tag, " dz@34"}, bus.div_zero, 1'b0);
    chk1({tag, " busy@34"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.srcA  = '0;
    bus.srcB  = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst hi", bus.hi, 32'h0);
    chk("rst lo", bus.lo, 32'h0);
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst done", bus.done, 1'b0);
    chk1("rst dz", bus.div_zero, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1, 1'b0);
    run_op("mult -3*7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1, 1'b1);
    run_op("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1, 1'b0);
    run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, -1, 1'b0);
    run_op("div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1, 1'b0);
    run_op("divu big", 2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, -1, 1'b0);
    run_op("divu /0", 2'b10, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1, -1, 1'b0);
    run_op("multu 6*7 disturbed", 2'b00, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 10, 1'b0);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi hi", bus.hi, 32'h12345678);
    chk("mthi lo kept", bus.lo, 32'h0000002A);

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("both we hi", bus.hi, 32'hCAFEF00D);
    chk("both we lo", bus.lo, 32'hCAFEF00D);

    bus.op    = 2'b11;
    bus.srcA  = 32'd1000;
    bus.srcB  = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst hi", bus.hi, 32'h0);
    chk("midrst lo", bus.lo, 32'h0);
    chk1("midrst busy", bus.busy, 1'b0);
    chk1("midrst done", bus.done, 1'b0);
    chk1("midrst dz", bus.div_zero, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu 2*3 after rst", 2'b00, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit in the execute stage, alongside the ALU. It consumes the same srcA/srcB operands and holds its results in HI/LO registers. HI/LO feed the writeback mux for MFHI/MFLO. Implements MULT, MULTU, DIV and DIVU with a start/busy/done handshake, plus direct HI/LO writes for MTHI/MTLO.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, 32, CALC iterations (must equal WIDTH)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
srcA  input  WIDTH  multiplicand / dividend
srcB  input  WIDTH  multiplier / divisor
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by an operation
div_zero  output  1  one-cycle pulse with done when a DIV/DIVU had srcB == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-operation):
  - state = IDLE; hi = lo = 0; busy = done = div_zero = 0.
  - Internal accumulators and counter are cleared; the operation in flight is lost.
- States:
  - IDLE -> CALC when start = 1.
  - CALC -> SIGN after ITER iterations.
  - SIGN -> IDLE.
- Start edge (E0, IDLE with start = 1):
  - Latch op.
  - Latch |srcA| and |srcB|; two's-complement abs only for signed ops (01, 11).
  - Latch the result signs: quotient/product sign = signA XOR signB; remainder sign = signA.
  - counter = 0; busy = 1 from the cycle after E0.
- CALC, multiply: radix-2 shift-add, one bit per cycle.
- CALC, divide: restoring, one quotient bit per cycle.
- SIGN edge (E33): apply sign correction, write hi/lo, busy = 0, done = 1 for the following cycle only.
- Latency: results valid and done = 1 exactly 33 rising edges after the edge that sampled start. Operations cannot overlap.
- Multiply result: 64-bit product; hi = upper word, lo = lower word. Signed product is the negated magnitude when signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0 (natural 32-bit wrap), with no flag.
- Divide by zero (srcB == 0): full 33-cycle latency still taken. hi = srcA as presented (original dividend), lo = 0xFFFFFFFF; div_zero pulses with done.
- start while busy: ignored, with no effect on the operation in flight.
- hi_we/lo_we:
  - In IDLE with start = 0: hi/lo <= wdata on the next edge. Both enables may fire in the same cycle.
  - While busy, or in the same cycle as an accepted start: ignored.
- op values are not checked; all four encodings are legal.
- hi/lo hold their value at all other times.

Test Plan:
- MULTU srcA = 0xFFFFFFFF, srcB = 0xFFFFFFFF -> after 33 edges hi = 0xFFFFFFFE, lo = 0x00000001, done pulses for 1 cycle; busy high during cycles 1..33.
- MULT srcA = 0xFFFFFFFD (-3), srcB = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
- DIV srcA = 0xFFFFFFF9 (-7), srcB = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). Also DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
- DIVU srcA = 100, srcB = 0 -> hi = 0x00000064, lo = 0xFFFFFFFF, div_zero = 1 coincident with done, at the 33rd edge.
- During a MULTU 6*7: pulse start with op = DIVU and assert hi_we with wdata = 0x12345678 at cycle 10 -> both ignored; final hi = 0, lo = 42. After done, hi_we with 0x12345678 -> hi = 0x12345678 next edge.
- rst_n low at cycle 15 of a DIV -> hi = lo = 0, busy = 0, done = 0 immediately. After release, a new MULTU 2*3 -> lo = 6, hi = 0, after 33 edges.
